tmds_period_sched: RTL
======================

Name: tmds_period_sched

Overview:
- Sequences TMDS link periods for the HDMI output path. It sits between the display timing generator and the three TMDS encoders and serializer.
- Delays the pixel/sync stream by a fixed lookahead. Using that lookahead, it inserts the HDMI video preamble and video leading guard band in the blanking immediately before each active line.
- Emits a per-cycle period code and CTL bits that tell the encoders what to transmit.

Parameters:
- PRE_LEN, 8, preamble length in pixel clocks; legal range >= 1.
- GB_LEN, 2, video guard-band length in pixel clocks; legal range >= 1.
- Derived value L = PRE_LEN + GB_LEN + 1 is the input-to-output latency in cycles.

Ports:
- clk_pix  in  1  pixel clock; all logic is on its rising edge.
- rst_pix_n  in  1  reset; synchronous, active-low.
- de  in  1  data enable from the timing generator.
- hsync  in  1  horizontal sync.
- vsync  in  1  vertical sync.
- red  in  8  pixel red.
- green  in  8  pixel green.
- blue  in  8  pixel blue.
- out_de  out  1  de delayed by L.
- out_hsync  out  1  hsync delayed by L.
- out_vsync  out  1  vsync delayed by L.
- out_red  out  8  red delayed by L.
- out_green  out  8  green delayed by L.
- out_blue  out  8  blue delayed by L.
- period  out  2  0 = CTRL, 1 = PREAMBLE, 2 = GUARD, 3 = VIDEO.
- ctl  out  4  {CTL3,CTL2,CTL1,CTL0}. The encoders use ctl[1:0] on green and ctl[3:2] on red.
- err_short_blank  out  1  sticky flag: a preamble was refused.

Behaviour:
- Reset (rst_pix_n low at a clock edge):
  - All outputs go to 0; period = CTRL.
  - Delay line is cleared (all stages de = 0); FSM goes to S_CTRL; err_short_blank is cleared.
  - Reset mid-preamble or mid-guard abandons the sequence. No residual preamble or guard appears after release.
- Delay line:
  - L registered stages carry {de, hsync, vsync, red, green, blue}.
  - Input at cycle n appears on the out_* ports at cycle n+L.
- Rising-edge detect:
  - rise = de & ~de_q, where de_q is de registered (reset 0).
- Accept rule:
  - rise is accepted only if the FSM is in S_CTRL and no delay-line stage holds de = 1.
  - If rise is not accepted: set err_short_blank. The pixels still pass through with period = VIDEO, with no preamble and no guard.
- FSM (cnt is a down-counter, width clog2(max(PRE_LEN, GB_LEN)) + 1):
  - S_CTRL: on accepted rise, go to S_PRE with cnt = PRE_LEN-1.
  - S_PRE: when cnt == 0, go to S_GUARD with cnt = GB_LEN-1; otherwise decrement cnt.
  - S_GUARD: when cnt == 0, go to S_CTRL; otherwise decrement cnt.
  - A de fall at the input during S_PRE or S_GUARD does not abort the sequence.
- Output timing for an accepted rise at input cycle t:
  - period = PREAMBLE on cycles t+1 .. t+PRE_LEN.
  - period = GUARD on cycles t+PRE_LEN+1 .. t+L-1.
  - out_de = 1 and period = VIDEO from cycle t+L.
- Period priority, per cycle, all registered:
  - If delayed de = 1: VIDEO.
  - Else if the FSM output stage is S_PRE: PREAMBLE.
  - Else if it is S_GUARD: GUARD.
  - Else: CTRL.
- ctl:
  - 4'b0001 during PREAMBLE; 4'b0000 otherwise.
  - Sync is always taken from out_hsync/out_vsync, including during PREAMBLE and GUARD.
- Single-cycle de pulse: produces the full PRE_LEN + GB_LEN sequence followed by exactly 1 VIDEO cycle.
- Back-to-back lines: any gap shorter than L cycles between de fall and the next rise is refused per the accept rule.

Optional Feature:
- Macro: TMDS_PERIOD_SCHED_HDMI_EN.
- Defined (HDMI mode): behaviour exactly as above.
- Undefined (DVI mode):
  - FSM, counter and err logic are compiled out.
  - period is only CTRL or VIDEO, following delayed de.
  - ctl = 0 always and err_short_blank is tied to 0.
  - Latency L is unchanged, so downstream timing is identical in both builds.

Test Plan:
1. Reset held 5 cycles with de = 1 toggling -> all outputs 0, period = 0 during reset and for L cycles after release while de = 0.
2. Defaults; 20 cycles de = 0, then de = 1 for 16 cycles with red = cycle index. If de rises at t:
   - period = 1 and ctl = 4'b0001 on t+1 .. t+8.
   - period = 2 and ctl = 0 on t+9 .. t+10.
   - period = 3 and out_red = cycle index on t+11 .. t+26.
   - period = 0 from t+27.
3. Single-cycle de pulse after long blanking -> 8 PREAMBLE cycles, 2 GUARD cycles, exactly 1 VIDEO cycle, then CTRL; err_short_blank = 0.
4. de high 4 cycles, low 5 cycles, high 4 cycles (gap 5 < 11):
   - The second line is output as VIDEO with no PREAMBLE/GUARD before it.
   - err_short_blank = 1 and stays 1 until reset.
5. rst_pix_n pulsed low for 1 cycle at t+4, during the preamble -> period = 0 from the cycle after the reset edge. No GUARD or VIDEO from the aborted line; the next clean line sequences normally.
6. Build without TMDS_PERIOD_SCHED_HDMI_EN, rerun scenario 2:
   - period is never 1 or 2 and ctl is always 0.
   - VIDEO is still on t+11 .. t+26, the same latency as the HDMI build.

Source files
------------

// File: rtl/tmds_period_sched.sv
// tmds_period_sched: sequences TMDS link periods (CTRL / PREAMBLE / GUARD /
// VIDEO) for an HDMI output. The pixel/sync stream is delayed by
// L = PRE_LEN + GB_LEN + 1 cycles, and that lookahead is used to place the
// video preamble and leading guard band in the blanking just before each line.
// Build option: define TMDS_PERIOD_SCHED_HDMI_EN for HDMI mode. Without it the
// block runs in DVI mode, where only CTRL/VIDEO are emitted and the latency is
// the same.
module tmds_period_sched #(
  parameter int PRE_LEN = 8,
  parameter int GB_LEN  = 2
) (
  input  logic       clk_pix,
  input  logic       rst_pix_n,
  input  logic       de,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic       out_de,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic [7:0] out_red,
  output logic [7:0] out_green,
  output logic [7:0] out_blue,
  output logic [1:0] period,
  output logic [3:0] ctl,
  output logic       err_short_blank
);

  localparam int L = PRE_LEN + GB_LEN + 1;

  typedef enum logic [1:0] {
    P_CTRL  = 2'd0,
    P_PRE   = 2'd1,
    P_GUARD = 2'd2,
    P_VIDEO = 2'd3
  } period_e;

  typedef struct packed {
    logic       de;
    logic       hsync;
    logic       vsync;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } px_t;

  px_t     in_px;
  px_t     pipe [L];   // pipe[0] is the newest stage, pipe[L-1] drives the outputs
  period_e period_d;

  assign in_px = '{de: de, hsync: hsync, vsync: vsync,
                   red: red, green: green, blue: blue};

  // Delay line: L stages of the full pixel/sync word.
  // NOTE: this storage is reset on purpose - a stale de=1 left in the line
  // would emit VIDEO after reset, so every stage is cleared.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      for (int i = 0; i < L; i++) pipe[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value
      // of its neighbour, so the line shifts by exactly one stage per clock.
      pipe[0] <= in_px;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign out_de    = pipe[L-1].de;
  assign out_hsync = pipe[L-1].hsync;
  assign out_vsync = pipe[L-1].vsync;
  assign out_red   = pipe[L-1].red;
  assign out_green = pipe[L-1].green;
  assign out_blue  = pipe[L-1].blue;

`ifdef TMDS_PERIOD_SCHED_HDMI_EN

  localparam int MAX_LEN = (PRE_LEN > GB_LEN) ? PRE_LEN : GB_LEN;
  localparam int CW      = $clog2(MAX_LEN) + 1;

  typedef enum logic [1:0] {
    S_CTRL  = 2'd0,
    S_PRE   = 2'd1,
    S_GUARD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rise, line_in_flight, accept, refuse;

  // A rising edge of de; pipe[0].de is de delayed by one clock.
  assign rise = de & ~pipe[0].de;

  // Any stage still carrying active video means the blanking is too short.
  always_comb begin
    line_in_flight = 1'b0;
    for (int i = 0; i < L; i++) line_in_flight |= pipe[i].de;
  end

  assign accept = rise && (state_q == S_CTRL) && !line_in_flight;
  assign refuse = rise && !accept;

  // Next-state logic for the preamble/guard sequencer.
  always_comb begin
    // NOTE: defaults first so every path assigns every output - no latches.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CTRL: begin
        if (accept) begin
          state_d = S_PRE;
          cnt_d   = CW'(PRE_LEN - 1);
        end
      end
      S_PRE: begin
        if (cnt_q == '0) begin
          state_d = S_GUARD;
          cnt_d   = CW'(GB_LEN - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GUARD: begin
        if (cnt_q == '0) state_d = S_CTRL;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_CTRL;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      state_q <= S_CTRL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Period selection for the next cycle: video wins, then preamble, then guard.
  always_comb begin
    if (pipe[L-2].de)            period_d = P_VIDEO;
    else if (state_d == S_PRE)   period_d = P_PRE;
    else if (state_d == S_GUARD) period_d = P_GUARD;
    else                         period_d = P_CTRL;
  end

  // Registered period, CTL code and sticky short-blanking flag.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      period          <= P_CTRL;
      ctl             <= 4'b0000;
      err_short_blank <= 1'b0;
    end else begin
      period          <= period_d;
      ctl             <= (period_d == P_PRE) ? 4'b0001 : 4'b0000;
      err_short_blank <= err_short_blank | refuse;
    end
  end

`else

  // DVI mode: the period simply follows the delayed data enable.
  always_comb begin
    period_d = pipe[L-2].de ? P_VIDEO : P_CTRL;
  end

  // Registered period so the latency matches the HDMI build.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) period <= P_CTRL;
    else            period <= period_d;
  end

  assign ctl             = 4'b0000;
  assign err_short_blank = 1'b0;

`endif

endmodule
